// File: rtl/rtc_ctrl.sv
// RTC sequencer: writes a start-up (or user-set) time into a BCD RTC over an
// I2C master, then periodically reads all six time registers back.
module rtc_ctrl #(
  parameter logic [19:0] INIT_WAIT   = 20'd1000,
  parameter logic [25:0] READ_PERIOD = 26'd50_000_000,
  parameter logic [19:0] IIC_TIMEOUT = 20'd1_000_000,
  parameter logic [47:0] INIT_TIME   = 48'h24_01_01_00_00_00
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        set_req,
  input  logic [47:0] set_time,
  input  logic        iic_end,
  input  logic [7:0]  rd_data,
  output logic        iic_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic [47:0] time_data,
  output logic        time_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    WAIT_INIT,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    WAIT_PERIOD
  } state_t;

  localparam logic [25:0] INIT_LAST    = {6'd0, INIT_WAIT} - 26'd1;
  localparam logic [25:0] PERIOD_LAST  = READ_PERIOD - 26'd1;
  localparam logic [25:0] TIMEOUT_LAST = {6'd0, IIC_TIMEOUT} - 26'd1;

  state_t      state;
  logic [25:0] cnt;
  logic [2:0]  idx;
  logic        pending;
  logic [47:0] set_buf;
  logic [47:0] wr_src;
  logic [47:0] shadow;

  logic [7:0]  cur_addr;
  logic [7:0]  cur_mask;
  logic [7:0]  cur_wr_byte;
  logic [7:0]  rd_masked;
  logic [47:0] shadow_next;

  assign addr_num = 1'b0;
  assign busy     = (state != WAIT_INIT) && (state != WAIT_PERIOD);

  // Register address, BCD field mask and byte lanes selected by the sweep index
  always_comb begin
    cur_addr    = 8'h00;
    cur_mask    = 8'h00;
    cur_wr_byte = 8'h00;
    shadow_next = shadow;
    rd_masked   = 8'h00;
    case (idx)
      3'd0: begin cur_addr = 8'h02; cur_mask = 8'h7F; cur_wr_byte = wr_src[7:0];   end
      3'd1: begin cur_addr = 8'h03; cur_mask = 8'h7F; cur_wr_byte = wr_src[15:8];  end
      3'd2: begin cur_addr = 8'h04; cur_mask = 8'h3F; cur_wr_byte = wr_src[23:16]; end
      3'd3: begin cur_addr = 8'h05; cur_mask = 8'h3F; cur_wr_byte = wr_src[31:24]; end
      3'd4: begin cur_addr = 8'h07; cur_mask = 8'h1F; cur_wr_byte = wr_src[39:32]; end
      3'd5: begin cur_addr = 8'h08; cur_mask = 8'hFF; cur_wr_byte = wr_src[47:40]; end
      default: ;
    endcase
    rd_masked = rd_data & cur_mask;
    case (idx)
      3'd0: shadow_next[7:0]   = rd_masked;
      3'd1: shadow_next[15:8]  = rd_masked;
      3'd2: shadow_next[23:16] = rd_masked;
      3'd3: shadow_next[31:24] = rd_masked;
      3'd4: shadow_next[39:32] = rd_masked;
      3'd5: shadow_next[47:40] = rd_masked;
      default: ;
    endcase
  end

  // Main sequencer; a set request is latched in every state and consumed at sweep start
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state      <= WAIT_INIT;
      cnt        <= 26'd0;
      idx        <= 3'd0;
      pending    <= 1'b0;
      set_buf    <= 48'h0;
      wr_src     <= 48'h0;
      shadow     <= 48'h0;
      iic_start  <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      byte_addr  <= 16'h0;
      wr_data    <= 8'h0;
      time_data  <= 48'h0;
      time_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      err        <= 1'b0;
      if (set_req) begin
        set_buf <= set_time;
        pending <= 1'b1;
      end
      case (state)
        WAIT_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt    <= 26'd0;
            idx    <= 3'd0;
            wr_src <= INIT_TIME;
            state  <= WR_ISSUE;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        WR_ISSUE: begin
          byte_addr <= {8'h00, cur_addr};
          wr_data   <= cur_wr_byte;
          wr_en     <= 1'b1;
          rd_en     <= 1'b0;
          iic_start <= 1'b1;
          cnt       <= 26'd0;
          state     <= WR_WAIT;
        end
        WR_WAIT: begin
          if (iic_end) begin
            iic_start <= 1'b0;
            wr_en     <= 1'b0;
            cnt       <= 26'd0;
            if (idx == 3'd5) begin
              idx   <= 3'd0;
              state <= RD_ISSUE;
            end else begin
              idx   <= idx + 3'd1;
              state <= WR_ISSUE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            iic_start <= 1'b0;
            wr_en     <= 1'b0;
            err       <= 1'b1;
            cnt       <= 26'd0;
            idx       <= 3'd0;
            state     <= WAIT_PERIOD;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        RD_ISSUE: begin
          byte_addr <= {8'h00, cur_addr};
          wr_data   <= 8'h00;
          wr_en     <= 1'b0;
          rd_en     <= 1'b1;
          iic_start <= 1'b1;
          cnt       <= 26'd0;
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (iic_end) begin
            iic_start <= 1'b0;
            rd_en     <= 1'b0;
            cnt       <= 26'd0;
            shadow    <= shadow_next;
            if (idx == 3'd5) begin
              time_data  <= shadow_next;
              time_valid <= 1'b1;
              idx        <= 3'd0;
              state      <= WAIT_PERIOD;
            end else begin
              idx   <= idx + 3'd1;
              state <= RD_ISSUE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            iic_start <= 1'b0;
            rd_en     <= 1'b0;
            err       <= 1'b1;
            cnt       <= 26'd0;
            idx       <= 3'd0;
            state     <= WAIT_PERIOD;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        WAIT_PERIOD: begin
          // A fresh set request cuts the idle period short
          if (set_req) begin
            wr_src  <= set_time;
            pending <= 1'b0;
            idx     <= 3'd0;
            cnt     <= 26'd0;
            state   <= WR_ISSUE;
          end else if (cnt == PERIOD_LAST) begin
            cnt <= 26'd0;
            idx <= 3'd0;
            if (pending) begin
              wr_src  <= set_buf;
              pending <= 1'b0;
              state   <= WR_ISSUE;
            end else begin
              state <= RD_ISSUE;
            end
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_ctrl.sv
// Scoreboard bench for rtc_ctrl: an I2C master model answers transactions while
// monitors compare commands, time updates and error pulses against queued expectations.
module tb_rtc_ctrl;

  localparam logic [19:0] INIT_WAIT   = 20'd20;
  localparam logic [25:0] READ_PERIOD = 26'd300;
  localparam logic [19:0] IIC_TIMEOUT = 20'd400;
  localparam logic [47:0] INIT_TIME   = 48'h24_01_01_00_00_00;
  localparam int          LATENCY     = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rstn;
  logic        set_req;
  logic [47:0] set_time;
  logic        iic_end;
  logic [7:0]  rd_data;
  logic        iic_start, wr_en, rd_en, addr_num;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;
  logic [47:0] time_data;
  logic        time_valid, busy, err;

  typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } txn_t;
  typedef struct packed { logic drop; logic [7:0] data; } resp_t;

  txn_t        exp_txn[$];
  resp_t       rd_resp[$];
  logic [47:0] exp_time[$];
  int          exp_err = 0;
  logic [47:0] last_time = 48'h0;
  int          pass_cnt = 0;
  int          check_cnt = 0;
  logic [7:0]  reg_tab [6] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08};

  rtc_ctrl #(
    .INIT_WAIT(INIT_WAIT), .READ_PERIOD(READ_PERIOD),
    .IIC_TIMEOUT(IIC_TIMEOUT), .INIT_TIME(INIT_TIME)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .set_req(set_req), .set_time(set_time),
    .iic_end(iic_end), .rd_data(rd_data), .iic_start(iic_start), .wr_en(wr_en),
    .rd_en(rd_en), .addr_num(addr_num), .byte_addr(byte_addr), .wr_data(wr_data),
    .time_data(time_data), .time_valid(time_valid), .busy(busy), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [47:0] t);
    @(negedge sys_clk);
    set_req  = 1'b1;
    set_time = t;
    @(negedge sys_clk);
    set_req  = 1'b0;
  endtask

  task automatic pushWrites(input logic [47:0] t);
    for (int i = 0; i < 6; i++) exp_txn.push_back({1'b1, reg_tab[i], t[8*i +: 8]});
  endtask

  task automatic pushReads(input logic [47:0] raw, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      exp_txn.push_back({1'b0, reg_tab[i], 8'h00});
      rd_resp.push_back({(i == drop_at), raw[8*i +: 8]});
    end
  endtask

  task automatic waitReadIssue(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge sys_clk);
      if (iic_start && rd_en) break;
    end
    if (k == budget) checkOutput("wait_read_issue", 64'(0), 64'(1));
  endtask

  // Master model: answers each transaction after LATENCY cycles or withholds iic_end
  txn_t       m_exp;
  logic       m_drop;
  logic [7:0] m_byte;
  logic       m_stable;
  logic [15:0] m_addr;
  initial begin
    iic_end = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (sys_rstn && iic_start) begin
        m_addr = byte_addr;
        if (exp_txn.size() == 0) begin
          checkOutput("txn_unexpected", 64'(byte_addr), 64'hFFFF);
        end else begin
          m_exp = exp_txn.pop_front();
          checkOutput("txn_type", 64'({wr_en, rd_en}), 64'(m_exp.wr ? 2'b10 : 2'b01));
          checkOutput("txn_addr", 64'(byte_addr), 64'({8'h00, m_exp.addr}));
          if (m_exp.wr) checkOutput("txn_wdata", 64'(wr_data), 64'(m_exp.data));
        end
        m_drop = 1'b0;
        m_byte = 8'h00;
        if (rd_en && rd_resp.size() > 0) {m_drop, m_byte} = rd_resp.pop_front();
        if (m_drop) begin
          for (int k = 0; k < int'(IIC_TIMEOUT) + 50 && iic_start && sys_rstn; k++)
            @(negedge sys_clk);
          checkOutput("timeout_release", 64'(iic_start), 64'(0));
        end else begin
          m_stable = 1'b1;
          for (int k = 0; k < LATENCY - 1; k++) begin
            @(negedge sys_clk);
            if (!sys_rstn) break;
            if (!iic_start || byte_addr !== m_addr) m_stable = 1'b0;
          end
          if (sys_rstn) begin
            checkOutput("cmd_stable", 64'(m_stable), 64'(1));
            iic_end = 1'b1;
            rd_data = m_byte;
            @(negedge sys_clk);
            iic_end = 1'b0;
            rd_data = 8'h00;
            checkOutput("start_drop", 64'(iic_start), 64'(0));
          end
        end
      end
    end
  end

  // Time update monitor
  always @(negedge sys_clk) begin
    if (sys_rstn && time_valid) begin
      if (exp_time.size() == 0) checkOutput("time_valid_unexpected", 64'(time_data), 64'(0));
      else checkOutput("time_data", 64'(time_data), 64'(exp_time.pop_front()));
      last_time = time_data;
    end
  end

  // Error pulse monitor
  always @(negedge sys_clk) begin
    if (sys_rstn && err) begin
      checkOutput("err_expected", 64'(exp_err > 0), 64'(1));
      if (exp_err > 0) exp_err--;
      checkOutput("err_start_low", 64'(iic_start), 64'(0));
      checkOutput("err_time_kept", 64'(time_data), 64'(last_time));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    sys_rstn = 1'b0;
    set_req  = 1'b0;
    set_time = 48'h0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_time_data", 64'(time_data), 64'(0));
    checkOutput("rst_ctrl", 64'({iic_start, wr_en, rd_en, time_valid, busy, err, addr_num}), 64'(0));
    checkOutput("rst_cmd", 64'({byte_addr, wr_data}), 64'(0));

    pushWrites(INIT_TIME);
    pushReads(48'h99_92_31_23_59_D9, 6, -1);
    exp_time.push_back(48'h99_12_31_23_59_59);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    repeat (5) @(negedge sys_clk);
    checkOutput("init_idle", 64'({busy, iic_start}), 64'(0));

    // Set request arrives mid-read; it is serviced after the next idle period
    waitReadIssue(2000);
    applyStimulus(48'h25_06_15_12_30_45);
    pushWrites(48'h25_06_15_12_30_45);
    pushReads(48'h25_06_15_12_30_45, 6, -1);
    exp_time.push_back(48'h25_06_15_12_30_45);
    pushReads(48'h0, 3, 2);
    exp_err = 1;
    pushReads(48'h26_E5_04_C3_02_81, 6, -1);
    exp_time.push_back(48'h26_05_04_03_02_01);

    for (k = 0; k < 10000; k++) begin
      @(negedge sys_clk);
      if (exp_time.size() == 0 && exp_err == 0) break;
    end
    if (k == 10000) checkOutput("wait_sweeps", 64'(exp_time.size()), 64'(0));

    // A set request during the idle period starts the write sweep at once
    repeat (10) @(negedge sys_clk);
    pushWrites(48'h20_12_25_08_15_30);
    pushReads(48'h0, 1, -1);
    applyStimulus(48'h20_12_25_08_15_30);
    checkOutput("set_immediate_busy", 64'(busy), 64'(1));

    // Reset during a read drops the request asynchronously and restarts from init
    waitReadIssue(2000);
    pushWrites(INIT_TIME);
    repeat (10) @(negedge sys_clk);
    #2 sys_rstn = 1'b0;
    #1;
    checkOutput("rst_mid_start", 64'(iic_start), 64'(0));
    checkOutput("rst_mid_time", 64'(time_data), 64'(0));
    checkOutput("rst_mid_busy", 64'({busy, rd_en}), 64'(0));
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;

    for (k = 0; k < 2000; k++) begin
      @(negedge sys_clk);
      if (exp_txn.size() == 0) break;
    end
    checkOutput("txn_queue_drained", 64'(exp_txn.size()), 64'(0));
    repeat (5) @(negedge sys_clk);
    checkOutput("time_queue_drained", 64'(exp_time.size()), 64'(0));
    checkOutput("err_consumed", 64'(exp_err), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
